line_planner: RTL and testbench

Upstream motion planner for the line-following car: synchronises and debounces the three line sensors, tracks the line with a small state machine, and drives the `mode`/`speed` inputs of the motor stage. An obstacle input forces an immediate stop. Speed changes are ramped so the PWM stage never sees step jumps from rest.

---
 rtl/planner_pkg.sv | 56 +++++
 rtl/sensor_debounce.sv | 42 ++++
 rtl/line_planner.sv | 157 +++++++++++++++
 tb/tb_line_planner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/planner_pkg.sv
// Shared encodings for the line planner: motor mode codes, tracking states, sensor decode results.
package planner_pkg;

  localparam int unsigned SPEED_W = 10;

  localparam logic [1:0] MODE_STOP  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_FWD   = 2'd3;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_FWD    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_RIGHT  = 3'd3,
    ST_SEARCH = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    DEC_FWD   = 3'd0,
    DEC_LEFT  = 3'd1,
    DEC_RIGHT = 3'd2,
    DEC_NONE  = 3'd3,
    DEC_HOLD  = 3'd4
  } decode_t;

  // Sensor bits are {left, mid, right}; 101 is ambiguous and means "keep going as before".
  function automatic decode_t decode_pattern(input logic [2:0] pattern);
    decode_t d;
    case (pattern)
      3'b010, 3'b111: d = DEC_FWD;
      3'b110, 3'b100: d = DEC_LEFT;
      3'b011, 3'b001: d = DEC_RIGHT;
      3'b000:         d = DEC_NONE;
      default:        d = DEC_HOLD;
    endcase
    return d;
  endfunction

  function automatic logic is_track(input decode_t d);
    return (d == DEC_FWD) || (d == DEC_LEFT) || (d == DEC_RIGHT);
  endfunction

  function automatic state_t track_state(input decode_t d);
    state_t s;
    case (d)
      DEC_FWD:   s = ST_FWD;
      DEC_LEFT:  s = ST_LEFT;
      DEC_RIGHT: s = ST_RIGHT;
      default:   s = ST_STOP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a stability filter: the output only takes a value that
// the synchronised input has held for DEB_CYCLES consecutive cycles.
module sensor_debounce #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned DEB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // cnt counts samples of cand seen so far; it saturates once the value is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= CNT_W'(1);
      end else if (cnt >= CNT_W'(DEB_CYCLES - 1)) begin
        stable <= cand;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/line_planner.sv
// Line-following motion planner: debounced sensor decode, tracking FSM, search timeout and speed command.
// Build option LINE_PLANNER_RAMP_EN adds the speed ramp; without it speed jumps to target on state entry.
module line_planner
  import planner_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 1000,
  parameter int unsigned RAMP_DIV     = 100000,
  parameter int unsigned RAMP_STEP    = 10,
  parameter int unsigned SPD_MIN      = 500,
  parameter int unsigned SPD_FWD      = 750,
  parameter int unsigned SPD_TURN     = 600,
  parameter int unsigned LOST_TIMEOUT = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sensor,
  input  logic       obstacle,
  output logic [1:0] mode,
  output logic [9:0] speed,
  output logic       lost
);

  localparam int unsigned SRCH_W = $clog2(LOST_TIMEOUT + 1);
  localparam logic [SPEED_W-1:0] TGT_FWD  = SPEED_W'(SPD_FWD);
  localparam logic [SPEED_W-1:0] TGT_TURN = SPEED_W'(SPD_TURN);

  if (SPD_MIN > 1023 || SPD_FWD > 1023 || SPD_TURN > 1023 || RAMP_STEP > 1023 ||
      RAMP_DIV == 0 || DEB_CYCLES == 0 || LOST_TIMEOUT == 0) begin : g_bad_params
    $error("line_planner: parameter out of range");
  end

  logic [2:0]        deb;
  decode_t           dec;
  state_t            state, state_nx;
  logic [1:0]        last_dir, last_dir_nx;
  logic [1:0]        mode_nx;
  logic [SPEED_W-1:0] speed_nx, tgt;
  logic              lost_nx, changed, moving;
  logic [SRCH_W-1:0] search_cnt, search_nx;

  sensor_debounce #(
    .WIDTH      (3),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .raw    (sensor),
    .stable (deb)
  );

`ifdef LINE_PLANNER_RAMP_EN
  localparam int unsigned DIV_W = $clog2(RAMP_DIV + 1);
  localparam logic [SPEED_W-1:0] MIN_SPD = SPEED_W'(SPD_MIN);

  logic [DIV_W-1:0]   div, div_nx;
  logic [SPEED_W:0]   sum;
  logic [SPEED_W-1:0] load;
  logic               from_rest;
`endif

  // Next state, and the registered outputs that go with it.
  always_comb begin
    dec         = decode_pattern(deb);
    state_nx    = state;
    last_dir_nx = last_dir;
    mode_nx     = MODE_STOP;
    tgt         = '0;
    speed_nx    = '0;
    search_nx   = '0;

    case (state)
      ST_SEARCH: begin
        if (is_track(dec))
          state_nx = track_state(dec);
        else if (search_cnt == SRCH_W'(LOST_TIMEOUT - 1))
          state_nx = ST_HALT;
      end
      ST_HALT: begin
        if (is_track(dec))
          state_nx = track_state(dec);
      end
      default: begin
        if (dec == DEC_NONE)
          state_nx = ST_SEARCH;
        else if (dec != DEC_HOLD)
          state_nx = track_state(dec);
      end
    endcase
    if (obstacle)
      state_nx = ST_STOP;

    changed = (state_nx != state);
    moving  = (state_nx == ST_FWD) || (state_nx == ST_LEFT) ||
              (state_nx == ST_RIGHT) || (state_nx == ST_SEARCH);
    lost_nx = (state_nx == ST_SEARCH) || (state_nx == ST_HALT);

    if (changed && state_nx == ST_LEFT)  last_dir_nx = MODE_LEFT;
    if (changed && state_nx == ST_RIGHT) last_dir_nx = MODE_RIGHT;

    case (state_nx)
      ST_FWD:    begin mode_nx = MODE_FWD;   tgt = TGT_FWD;  end
      ST_LEFT:   begin mode_nx = MODE_LEFT;  tgt = TGT_TURN; end
      ST_RIGHT:  begin mode_nx = MODE_RIGHT; tgt = TGT_TURN; end
      ST_SEARCH: begin mode_nx = last_dir;   tgt = TGT_TURN; end
      default:   begin mode_nx = MODE_STOP;  tgt = '0;       end
    endcase

    if (state_nx == ST_SEARCH && !changed)
      search_nx = search_cnt + SRCH_W'(1);

`ifdef LINE_PLANNER_RAMP_EN
    div_nx    = '0;
    sum       = {1'b0, speed} + (SPEED_W + 1)'(RAMP_STEP);
    load      = (MIN_SPD > tgt) ? tgt : MIN_SPD;
    from_rest = (state == ST_STOP) || (state == ST_HALT);
    // Starts from rest begin at the minimum; hand-overs between moving states never speed up.
    if (!moving)
      speed_nx = '0;
    else if (changed)
      speed_nx = from_rest ? load : ((speed < tgt) ? speed : tgt);
    else if (div == DIV_W'(RAMP_DIV - 1))
      speed_nx = (sum > {1'b0, tgt}) ? tgt : sum[SPEED_W-1:0];
    else begin
      speed_nx = speed;
      div_nx   = div + DIV_W'(1);
    end
`else
    speed_nx = moving ? tgt : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_STOP;
      mode       <= MODE_STOP;
      speed      <= '0;
      lost       <= 1'b0;
      last_dir   <= MODE_LEFT;
      search_cnt <= '0;
    end else begin
      state      <= state_nx;
      mode       <= mode_nx;
      speed      <= speed_nx;
      lost       <= lost_nx;
      last_dir   <= last_dir_nx;
      search_cnt <= search_nx;
    end
  end

`ifdef LINE_PLANNER_RAMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div <= '0;
    else     div <= div_nx;
  end
`endif

endmodule

// File: tb/tb_line_planner.sv
// Directed bench for line_planner with small timing parameters; expectations follow the build option.
module tb_line_planner;

`ifdef LINE_PLANNER_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sensor;
  logic       obstacle;
  logic [1:0] mode;
  logic [9:0] speed;
  logic       lost;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] em;
  logic [9:0] es;
  logic       el;

  always #5 clk = ~clk;

  line_planner #(
    .DEB_CYCLES   (4),
    .RAMP_DIV     (3),
    .RAMP_STEP    (100),
    .SPD_MIN      (500),
    .SPD_FWD      (750),
    .SPD_TURN     (600),
    .LOST_TIMEOUT (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sensor   (sensor),
    .obstacle (obstacle),
    .mode     (mode),
    .speed    (speed),
    .lost     (lost)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; obstacle = 1'b1; sensor = 3'b000;
    #12;
    {em, es, el} = {2'd0, 10'd0, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL reset_values: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(2);
    rst = 1'b0;
    tick(3);
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL obstacle_idle: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
  endtask

  task automatic test_fwd_ramp();
    int e;
    sensor = 3'b010;
    tick(6);
    {em, es, el} = {2'd0, 10'd0, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL fwd_blocked: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    obstacle = 1'b0;
    tick(1);
    {em, es, el} = {2'd3, (RAMP ? 10'd500 : 10'd750), 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL fwd_entry: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      e = 500 + 100 * (k / 3);
      if (e > 750) e = 750;
      es = RAMP ? 10'(e) : 10'd750;
      n_checks++;
      if (mode !== em || speed !== es || lost !== el) begin
        n_fail++;
        $display("FAIL fwd_ramp[%0d]: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", k, mode, speed, lost, em, es, el);
      end
    end
  endtask

  task automatic test_glitch();
    sensor = 3'b000;
    tick(2);
    sensor = 3'b010;
    {em, es, el} = {2'd3, 10'd750, 1'b0};
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_checks++;
      if (mode !== em || speed !== es || lost !== el) begin
        n_fail++;
        $display("FAIL glitch[%0d]: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", k, mode, speed, lost, em, es, el);
      end
    end
  endtask

  task automatic test_hold();
    sensor = 3'b101;
    {em, es, el} = {2'd3, 10'd750, 1'b0};
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_checks++;
      if (mode !== em || speed !== es || lost !== el) begin
        n_fail++;
        $display("FAIL hold[%0d]: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", k, mode, speed, lost, em, es, el);
      end
    end
    sensor = 3'b010;
    tick(8);
  endtask

  task automatic test_search_halt();
    sensor = 3'b000;
    tick(6);
    {em, es, el} = {2'd3, 10'd750, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_latency: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(1);
    {em, es, el} = {2'd1, 10'd600, 1'b1};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_entry: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(19);
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_last: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(1);
    {em, es, el} = {2'd0, 10'd0, 1'b1};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL halt_entry: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(5);
    sensor = 3'b001;
    tick(6);
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL halt_wait: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(1);
    {em, es, el} = {2'd2, (RAMP ? 10'd500 : 10'd600), 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL halt_exit: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(3);
    es = 10'd600;
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL halt_ramp: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
  endtask

  task automatic test_search_recover();
    sensor = 3'b011;
    tick(8);
    {em, es, el} = {2'd2, 10'd600, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL right_steady: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    sensor = 3'b000;
    tick(7);
    {em, es, el} = {2'd2, 10'd600, 1'b1};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_right: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(4);
    sensor = 3'b010;
    tick(6);
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_wait: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(1);
    {em, es, el} = {2'd3, (RAMP ? 10'd600 : 10'd750), 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL search_to_fwd: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
  endtask

  task automatic test_obstacle();
    tick(1);
    obstacle = 1'b1;
    tick(1);
    {em, es, el} = {2'd0, 10'd0, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL obstacle_stop: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    sensor = 3'b100;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      n_checks++;
      if (mode !== em || speed !== es || lost !== el) begin
        n_fail++;
        $display("FAIL obstacle_hold[%0d]: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", k, mode, speed, lost, em, es, el);
      end
    end
    obstacle = 1'b0;
    tick(1);
    {em, es, el} = {2'd1, (RAMP ? 10'd500 : 10'd600), 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL obstacle_release: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(3);
    es = 10'd600;
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL release_ramp: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    {em, es, el} = {2'd0, 10'd0, 1'b0};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL async_reset: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    {em, es, el} = {2'd1, (RAMP ? 10'd500 : 10'd600), 1'b1};
    n_checks++;
    if (mode !== em || speed !== es || lost !== el) begin
      n_fail++;
      $display("FAIL post_reset_search: mode=%0d speed=%0d lost=%0b, expected mode=%0d speed=%0d lost=%0b", mode, speed, lost, em, es, el);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ramp();
    test_glitch();
    test_hold();
    test_search_halt();
    test_search_recover();
    test_obstacle();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
